// File: rtl/fifo_read_packer.sv
// +---------------------------------------------------------------------------+
// | fifo_read_packer: drains a synchronous FIFO and packs PACK entries into a |
// | wide valid/ready word; partial words leave on flush or idle timeout.      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module fifo_read_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  output logic                       fifo_r_en,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PACK*DATA_WIDTH-1:0] out_data,
  output logic [PACK-1:0]            out_keep
);

  localparam int LW = $clog2(PACK) + 1;
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_run;
  logic            r_rd_pend;
  logic [LW-1:0]   r_lane_cnt;
  logic [IW-1:0]   r_idle_cnt;

  logic [LW:0]     w_inflight;
  logic            w_has_lanes;
  logic            w_timeout;
  logic            w_close;
  logic            w_last_lane;
  logic            w_idle_sat;
  logic [PACK-1:0] w_part_keep;

  assign w_inflight  = {1'b0, r_lane_cnt} + {{LW{1'b0}}, r_rd_pend};
  assign w_has_lanes = (r_lane_cnt != '0);
  assign w_last_lane = r_rd_pend && (r_lane_cnt == LW'(PACK - 1));
  assign w_idle_sat  = (r_idle_cnt == '1);

  assign fifo_r_en = r_run && (r_state == FILL) && !fifo_empty && !flush &&
                     (w_inflight < (LW + 1)'(PACK));

  // Timeout only fires while the FIFO is still empty, so it can never race
  // a read issued in the same cycle; fresh data simply keeps filling lanes.
  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign w_timeout = (r_idle_cnt == IW'(TIMEOUT)) && fifo_empty;
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  assign w_close = (r_state == FILL) && w_has_lanes && !r_rd_pend &&
                   (flush || w_timeout);

  always_comb begin
    w_part_keep = '0;
    for (int i = 0; i < PACK; i++) begin
      w_part_keep[i] = (r_lane_cnt > LW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FILL;
      r_run      <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_lane_cnt <= '0;
      r_idle_cnt <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
    end else begin
      r_run     <= 1'b1;
      r_rd_pend <= fifo_r_en;
      case (r_state)
        FILL: begin
          if (r_rd_pend) begin
            for (int i = 0; i < PACK; i++) begin
              if (r_lane_cnt == LW'(i)) begin
                out_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
              end
            end
            r_lane_cnt <= r_lane_cnt + LW'(1);
            r_idle_cnt <= '0;
            if (w_last_lane) begin
              r_state   <= HOLD;
              out_valid <= 1'b1;
              out_keep  <= '1;
            end
          end else if (w_close) begin
            r_state   <= HOLD;
            out_valid <= 1'b1;
            out_keep  <= w_part_keep;
          end else if (!w_has_lanes) begin
            r_idle_cnt <= '0;
          end else if (fifo_empty && !w_idle_sat) begin
            r_idle_cnt <= r_idle_cnt + IW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state    <= FILL;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            r_lane_cnt <= '0;
            r_idle_cnt <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_packer.sv
// +---------------------------------------------------------------------------+
// | tb_fifo_read_packer: directed bench with FIFO model and word scoreboard.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_read_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_r_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  fifo_read_packer #(.DATA_WIDTH(8), .PACK(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
  } word_t;

  word_t exp_q[$];
  int    rd_cycles[$];
  int    word_cycles[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    rd_count = 0;
  int    word_count = 0;
  int    cyc = 0;

  // Simple FIFO model with one-cycle read latency
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       fifo_clear = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_clear) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_r_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
    word_t w;
    w.d = d;
    w.k = k;
    exp_q.push_back(w);
  endtask

  task automatic clear_stats();
    rd_count   = 0;
    word_count = 0;
    rd_cycles.delete();
    word_cycles.delete();
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int k = 0;
    while (word_count < n && k < budget) begin
      step();
      k++;
    end
    check(tag, word_count >= n, 1);
  endtask

  function automatic int rd_at(input int i);
    return (i < rd_cycles.size()) ? rd_cycles[i] : -1000;
  endfunction

  function automatic int wd_at(input int i);
    return (i < word_cycles.size()) ? word_cycles[i] : 1000;
  endfunction

  // Monitor: protocol rules, hold stability and scoreboard
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("rd_when_empty", fifo_r_en && fifo_empty, 0);
      if (out_valid) check("rd_in_hold", fifo_r_en, 0);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_keep", out_keep, prev_keep);
      end
      if (fifo_r_en) begin
        rd_count++;
        rd_cycles.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        word_count++;
        word_cycles.push_back(cyc);
        check("sb_expected_word", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          word_t w;
          w = exp_q.pop_front();
          check("sb_data", out_data, w.d);
          check("sb_keep", out_keep, w.k);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_keep  = out_keep;
    end
  end

  initial begin
    int rel_cyc;
    int dt;
    int wc;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state with a non-empty FIFO, then first word
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    step(); step();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_keep", out_keep, 0);
    check("rst_r_en", fifo_r_en, 0);
    clear_stats();
    expect_word(32'h44332211, 4'b1111);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    #1;
    check("r_en_before_run", fifo_r_en, 0);
    wait_words("t1_word", 1, 30);
    check("t1_reads", rd_count, 4);
    check("t1_first_read", rd_at(0), rel_cyc + 1);
    check("t1_back_to_back", rd_at(3) - rd_at(0), 3);
    check("t1_latency", wd_at(0) - rd_at(0), 5);
    check("t1_pulse", out_valid, 0);

    // Backpressure: first word held for 20 cycles, then second word
    clear_stats();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(8'h11 * i));
    expect_word(32'h44332211, 4'b1111);
    expect_word(32'h88776655, 4'b1111);
    begin
      int k = 0;
      while (!out_valid && k < 20) begin
        step();
        k++;
      end
    end
    check("t2_valid", out_valid, 1);
    repeat (20) step();
    check("t2_held_data", out_data, 32'h44332211);
    check("t2_reads_stalled", rd_count, 4);
    out_ready = 1'b1;
    wait_words("t2_words", 2, 30);
    check("t2_reads", rd_count, 8);

    // Idle timeout emits a partial word
    clear_stats();
    push(8'hA1); push(8'hB2);
    expect_word(32'h0000B2A1, 4'b0011);
    wait_words("t3_word", 1, 40);
    check("t3_reads", rd_count, 2);
    dt = wd_at(0) - rd_at(0);
    check("t3_timeout_window", (dt >= 19) && (dt <= 20), 1);

    // Flush arriving while the last read is pending
    clear_stats();
    push(8'h01); push(8'h02); push(8'h03);
    expect_word(32'h00030201, 4'b0111);
    begin
      int k = 0;
      while (rd_count < 3 && k < 10) begin
        step();
        k++;
      end
    end
    check("t4_reads", rd_count, 3);
    flush = 1'b1;
    step(); step();
    flush = 1'b0;
    wait_words("t4_word", 1, 10);

    // Flush with no lanes filled emits nothing
    wc    = word_count;
    flush = 1'b1;
    repeat (5) step();
    flush = 1'b0;
    repeat (25) step();
    check("t4_empty_flush", word_count, wc);
    check("t4_empty_valid", out_valid, 0);

    // Reset mid-operation discards partial lanes
    clear_stats();
    push(8'hE1); push(8'hE2);
    repeat (5) step();
    rst_n = 1'b0;
    push(8'hE3);
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_keep", out_keep, 0);
    fifo_clear = 1'b1;
    step();
    check("t5_rst_r_en_a", fifo_r_en, 0);
    step();
    check("t5_rst_r_en_b", fifo_r_en, 0);
    fifo_clear = 1'b0;
    rst_n      = 1'b1;
    clear_stats();
    push(8'h55); push(8'h56); push(8'h57); push(8'h58);
    expect_word(32'h58575655, 4'b1111);
    wait_words("t5_word", 1, 30);

    // Continuous stream: one word every PACK+2 cycles
    clear_stats();
    for (int i = 0; i < 12; i++) push(8'(8'h61 + i));
    expect_word(32'h64636261, 4'b1111);
    expect_word(32'h68676665, 4'b1111);
    expect_word(32'h6C6B6A69, 4'b1111);
    wait_words("t6_words", 3, 60);
    check("t6_reads", rd_count, 12);
    check("t6_latency", wd_at(0) - rd_at(0), 5);
    check("t6_period_a", wd_at(1) - wd_at(0), 6);
    check("t6_period_b", wd_at(2) - wd_at(1), 6);

    repeat (3) step();
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
